// File: rtl/mm_to_st_fifo_32_bit.sv
// -----------------------------------------------------------------------------
// mm_to_st_fifo_32_bit
//
// Processor-to-fabric path: an Avalon-MM write slave feeds a single-clock FIFO
// that drains onto an Avalon-ST source (ready latency 0).
//
// Storage is a synchronous-read RAM of DEPTH-2 words followed by a two-entry
// output buffer (prefetch register fed by the RAM read port, then the output
// register).  This gives 1 word/clock sustained throughput with a total
// capacity of exactly 2**DEPTH_LOG2 words.
//
// Ports
//   wrclock                          single clock, rising edge
//   reset_n                          asynchronous active-low reset
//   avalonmm_write_slave_address     0 = data port, 1 = control/status port
//   avalonmm_write_slave_write       write strobe
//   avalonmm_write_slave_writedata   data word (addr 0) / control (addr 1, bit0 = flush)
//   avalonmm_write_slave_read        read strobe (status only)
//   avalonmm_write_slave_readdata    {full, empty, flush_busy(0), 0.., level}
//   avalonmm_write_slave_waitrequest stalls data writes while full
//   avalonst_source_data             stream data
//   avalonst_source_valid            stream valid
//   avalonst_source_ready            stream ready
// -----------------------------------------------------------------------------
module mm_to_st_fifo_32_bit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  wrclock,
  input  logic                  reset_n,
  input  logic                  avalonmm_write_slave_address,
  input  logic                  avalonmm_write_slave_write,
  input  logic [DATA_WIDTH-1:0] avalonmm_write_slave_writedata,
  input  logic                  avalonmm_write_slave_read,
  output logic [31:0]           avalonmm_write_slave_readdata,
  output logic                  avalonmm_write_slave_waitrequest,
  output logic [DATA_WIDTH-1:0] avalonst_source_data,
  output logic                  avalonst_source_valid,
  input  logic                  avalonst_source_ready
);

  localparam int DEPTH      = 2 ** DEPTH_LOG2;
  localparam int RAM_WORDS  = DEPTH - 2;
  localparam int STATUS_PAD = 29 - (DEPTH_LOG2 + 1);

  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST  = DEPTH_LOG2'(RAM_WORDS - 1);
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO  = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_MAX   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  // State
  logic [DATA_WIDTH-1:0] r_mem [0:RAM_WORDS-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_pf_valid;
  logic [DATA_WIDTH-1:0] r_pf_data;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  // Decoded control
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_out_load;
  logic                  w_ram_rd;
  logic                  w_ram_has_data;
  logic [DEPTH_LOG2:0]   w_stage_cnt;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   w_level_nxt;
  logic [31:0]           w_status;
  logic [31:0]           w_readdata;

  // Decode of MM accesses, occupancy flags and the output-buffer handshake
  always_comb begin
    w_full   = (r_level == LVL_MAX);
    w_empty  = (r_level == LVL_ZERO);
    w_wr_acc = avalonmm_write_slave_write & ~avalonmm_write_slave_address & ~w_full;
    w_flush  = avalonmm_write_slave_write & avalonmm_write_slave_address &
               avalonmm_write_slave_writedata[0];
    w_pop    = r_out_valid & avalonst_source_ready;
    // Output register takes the prefetched word when empty or emptying.
    w_out_load = r_pf_valid & (~r_out_valid | w_pop);
    // Words in the RAM = level minus words parked in the two buffer stages.
    w_stage_cnt    = {{(DEPTH_LOG2-1){1'b0}}, r_pf_valid & r_out_valid,
                      r_pf_valid ^ r_out_valid};
    w_ram_has_data = (r_level != w_stage_cnt);
    // Read the RAM only when the prefetch slot is (or is becoming) free.
    w_ram_rd = w_ram_has_data & (~r_pf_valid | w_out_load);
  end

  // Pointer wrap modulo the RAM size, with no unused slot
  always_comb begin
    if (r_wr_ptr == PTR_LAST) begin
      w_wr_ptr_nxt = PTR_ZERO;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    end
    if (r_rd_ptr == PTR_LAST) begin
      w_rd_ptr_nxt = PTR_ZERO;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end
  end

  // Next occupancy: a simultaneous accept and transfer leaves it unchanged
  always_comb begin
    case ({w_wr_acc, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Status word and read-data mux (zero-wait, combinational)
  always_comb begin
    w_status = {w_full, w_empty, 1'b0, {STATUS_PAD{1'b0}}, r_level};
    if (avalonmm_write_slave_read && avalonmm_write_slave_address) begin
      w_readdata = w_status;
    end else begin
      w_readdata = 32'h0000_0000;
    end
  end

  // RAM write port; kept out of the reset domain so it maps onto block RAM
  always_ff @(posedge wrclock) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= avalonmm_write_slave_writedata;
    end
  end

  // Pointers, occupancy and the two output-buffer stages
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= PTR_ZERO;
      r_rd_ptr    <= PTR_ZERO;
      r_level     <= LVL_ZERO;
      r_pf_valid  <= 1'b0;
      r_pf_data   <= DATA_ZERO;
      r_out_valid <= 1'b0;
      r_out_data  <= DATA_ZERO;
    end else if (w_flush) begin
      // A transfer on this edge still completes at the sink; the rest is dropped.
      r_wr_ptr    <= PTR_ZERO;
      r_rd_ptr    <= PTR_ZERO;
      r_level     <= LVL_ZERO;
      r_pf_valid  <= 1'b0;
      r_pf_data   <= DATA_ZERO;
      r_out_valid <= 1'b0;
      r_out_data  <= DATA_ZERO;
    end else begin
      r_level <= w_level_nxt;
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_ram_rd) begin
        r_rd_ptr   <= w_rd_ptr_nxt;
        r_pf_data  <= r_mem[r_rd_ptr];
        r_pf_valid <= 1'b1;
      end else if (w_out_load) begin
        r_pf_valid <= 1'b0;
      end
      // Output data only moves on load, so it holds while valid & !ready.
      if (w_out_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_pf_data;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign avalonmm_write_slave_readdata    = w_readdata;
  assign avalonmm_write_slave_waitrequest = avalonmm_write_slave_write &
                                            ~avalonmm_write_slave_address & w_full;
  assign avalonst_source_data             = r_out_data;
  assign avalonst_source_valid            = r_out_valid;

endmodule

// File: tb/tb_mm_to_st_fifo_32_bit.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for mm_to_st_fifo_32_bit with DEPTH_LOG2 = 4
// (16-word capacity).  A negedge monitor collects every stream transfer; the
// bench keeps its own queue of accepted words and compares the two.
// -----------------------------------------------------------------------------
module tb_mm_to_st_fifo_32_bit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        av_addr;
  logic        av_write;
  logic        av_read;
  logic [31:0] av_wdata;
  logic [31:0] av_rdata;
  logic        av_wait;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rx_q  [$];
  int          rx_cyc [$];
  logic        stab_en = 1'b0;
  logic        prev_v  = 1'b0;
  logic        prev_r  = 1'b0;
  logic [31:0] prev_d  = 32'h0;
  int          max_out = 0;
  logic        t3_done;

  mm_to_st_fifo_32_bit #(.DATA_WIDTH(32), .DEPTH_LOG2(4)) dut (
    .wrclock                          (clk),
    .reset_n                          (reset_n),
    .avalonmm_write_slave_address     (av_addr),
    .avalonmm_write_slave_write       (av_write),
    .avalonmm_write_slave_writedata   (av_wdata),
    .avalonmm_write_slave_read        (av_read),
    .avalonmm_write_slave_readdata    (av_rdata),
    .avalonmm_write_slave_waitrequest (av_wait),
    .avalonst_source_data             (st_data),
    .avalonst_source_valid            (st_valid),
    .avalonst_source_ready            (st_ready)
  );

  always #5 clk = ~clk;

  // Cycle counter used to check back-to-back delivery
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stream sink: records transfers, checks hold-while-stalled, tracks occupancy
  always @(negedge clk) begin
    if (reset_n) begin
      if (stab_en && prev_v && !prev_r) begin
        check_eq("stall_valid_held", {31'h0, st_valid}, 32'h1);
        check_eq("stall_data_held", st_data, prev_d);
      end
      if (exp_q.size() - rx_q.size() > max_out) max_out = exp_q.size() - rx_q.size();
      if (st_valid && st_ready) begin
        rx_q.push_back(st_data);
        rx_cyc.push_back(cyc);
      end
    end
    prev_v = st_valid;
    prev_r = st_ready;
    prev_d = st_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mm_idle();
    av_write = 1'b0;
    av_read  = 1'b0;
    av_addr  = 1'b0;
    av_wdata = 32'h0;
  endtask

  // Issue one write and hold it until accepted; returns at posedge+1 with write still high
  task automatic mm_write(input logic addr, input logic [31:0] data, output int stalls);
    logic w;
    logic done;
    stalls   = 0;
    done     = 1'b0;
    av_write = 1'b1;
    av_read  = 1'b0;
    av_addr  = addr;
    av_wdata = data;
    while (!done) begin
      @(negedge clk);
      w = av_wait;
      @(posedge clk);
      #1;
      if (!w) begin
        done = 1'b1;
        if (!addr) exp_q.push_back(data);
      end else begin
        stalls++;
        if (stalls >= 300) begin
          check_eq("write_timeout", 32'(stalls), 32'h0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic status_read(output logic [31:0] rd);
    av_write = 1'b0;
    av_addr  = 1'b1;
    av_read  = 1'b1;
    #1;
    rd       = av_rdata;
    av_read  = 1'b0;
    av_addr  = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (rx_q.size() < exp_q.size() && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check_eq({tag, "_word"}, rx_q[i], exp_q[i]);
  endtask

  task automatic clear_q();
    exp_q.delete();
    rx_q.delete();
    rx_cyc.delete();
  endtask

  initial begin
    int          s;
    int          total;
    logic [31:0] rd;

    // ---------------- reset state
    reset_n  = 1'b0;
    st_ready = 1'b0;
    mm_idle();
    repeat (3) step();
    check_eq("rst_valid", {31'h0, st_valid}, 32'h0);
    check_eq("rst_data", st_data, 32'h0);
    check_eq("rst_wait", {31'h0, av_wait}, 32'h0);
    reset_n = 1'b1;
    step();
    status_read(rd);
    check_eq("rst_status", rd, 32'h4000_0000);

    // ---------------- T1: back-to-back with ready high
    clear_q();
    st_ready = 1'b1;
    total    = 0;
    for (int i = 1; i <= 16; i++) begin
      mm_write(1'b0, 32'(i), s);
      total += s;
      if (i < 3) check_eq("t1_latency_invalid", {31'h0, st_valid}, 32'h0);
      if (i == 3) begin
        check_eq("t1_latency_valid", {31'h0, st_valid}, 32'h1);
        check_eq("t1_first_word", st_data, 32'h1);
      end
    end
    mm_idle();
    wait_drain(20);
    compare_stream("t1");
    check_eq("t1_stalls", 32'(total), 32'h0);
    if (rx_cyc.size() == 16) check_eq("t1_one_per_clock", 32'(rx_cyc[15] - rx_cyc[0]), 32'd15);
    else check_eq("t1_rx_cycles", 32'(rx_cyc.size()), 32'd16);

    // ---------------- T2: fill with ready low, 17th write stalls
    clear_q();
    st_ready = 1'b0;
    for (int i = 1; i <= 16; i++) mm_write(1'b0, 32'h100 + 32'(i), s);
    av_wdata = 32'h111;
    #1;
    check_eq("t2_stall", {31'h0, av_wait}, 32'h1);
    step();
    step();
    check_eq("t2_stall_held", {31'h0, av_wait}, 32'h1);
    check_eq("t2_head_valid", {31'h0, st_valid}, 32'h1);
    check_eq("t2_head_data", st_data, 32'h101);
    st_ready = 1'b1;
    step();
    st_ready = 1'b0;
    #1;
    check_eq("t2_release", {31'h0, av_wait}, 32'h0);
    step();
    exp_q.push_back(32'h111);
    status_read(rd);
    check_eq("t2_status_full", rd, 32'h8000_0010);
    check_eq("t2_one_out", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() > 0) check_eq("t2_out_word", rx_q[0], 32'h101);
    mm_idle();
    st_ready = 1'b1;
    wait_drain(40);
    compare_stream("t2");

    // ---------------- T3: random back-pressure, 1000 random words
    clear_q();
    max_out = 0;
    stab_en = 1'b1;
    t3_done = 1'b0;
    fork
      begin
        int ss;
        for (int i = 0; i < 1000; i++) mm_write(1'b0, $urandom, ss);
        mm_idle();
        t3_done = 1'b1;
      end
      begin
        while (!t3_done) begin
          step();
          st_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    st_ready = 1'b1;
    wait_drain(100);
    stab_en = 1'b0;
    compare_stream("t3");
    check_eq("t3_level_bound", {31'h0, max_out <= 16}, 32'h1);

    // ---------------- T4: status, no-op control, flush, post-flush order
    clear_q();
    st_ready = 1'b0;
    for (int i = 0; i < 10; i++) mm_write(1'b0, 32'hD0 + 32'(i), s);
    mm_idle();
    repeat (3) step();
    check_eq("t4_valid", {31'h0, st_valid}, 32'h1);
    check_eq("t4_head", st_data, 32'hD0);
    status_read(rd);
    check_eq("t4_status_10", rd, 32'h0000_000A);
    av_addr = 1'b0;
    av_read = 1'b1;
    #1;
    check_eq("t4_read_addr0", av_rdata, 32'h0);
    av_read = 1'b0;
    mm_write(1'b1, 32'h2, s);
    mm_idle();
    status_read(rd);
    check_eq("t4_noop_ctrl", rd, 32'h0000_000A);
    mm_write(1'b1, 32'h1, s);
    check_eq("t4_flush_valid", {31'h0, st_valid}, 32'h0);
    mm_idle();
    status_read(rd);
    check_eq("t4_flush_status", rd, 32'h4000_0000);
    clear_q();
    st_ready = 1'b1;
    mm_write(1'b0, 32'hCAFE_F00D, s);
    mm_idle();
    wait_drain(10);
    repeat (3) step();
    compare_stream("t4");

    // ---------------- T5: reset while full with a stalled master
    clear_q();
    st_ready = 1'b0;
    for (int i = 0; i < 16; i++) mm_write(1'b0, 32'hE0 + 32'(i), s);
    av_wdata = 32'h12;
    #1;
    check_eq("t5_stalled", {31'h0, av_wait}, 32'h1);
    step();
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_wait", {31'h0, av_wait}, 32'h0);
    check_eq("t5_rst_valid", {31'h0, st_valid}, 32'h0);
    check_eq("t5_rst_data", st_data, 32'h0);
    status_read(rd);
    check_eq("t5_rst_status", rd, 32'h4000_0000);
    mm_idle();
    clear_q();
    step();
    reset_n = 1'b1;
    step();
    mm_write(1'b0, 32'h1234_5678, s);
    mm_idle();
    check_eq("t5_lat0", {31'h0, st_valid}, 32'h0);
    step();
    check_eq("t5_lat1", {31'h0, st_valid}, 32'h0);
    step();
    check_eq("t5_lat2_valid", {31'h0, st_valid}, 32'h1);
    check_eq("t5_lat2_data", st_data, 32'h1234_5678);
    st_ready = 1'b1;
    wait_drain(10);
    compare_stream("t5");

    // ---------------- T6: flush on the same edge as a stream transfer
    clear_q();
    st_ready = 1'b0;
    for (int i = 1; i <= 3; i++) mm_write(1'b0, 32'hAAAA_0000 + 32'(i), s);
    mm_idle();
    repeat (3) step();
    check_eq("t6_head", st_data, 32'hAAAA_0001);
    clear_q();
    st_ready = 1'b1;
    mm_write(1'b1, 32'h1, s);
    mm_idle();
    repeat (4) step();
    exp_q.push_back(32'hAAAA_0001);
    compare_stream("t6");
    check_eq("t6_valid", {31'h0, st_valid}, 32'h0);
    status_read(rd);
    check_eq("t6_status", rd, 32'h4000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
